regfile_wb_arbiter: RTL and testbench
=====================================

# regfile_wb_arbiter

Write-port controller for the 32x32 RV32 register file. Shares the single regfile write port (write enable, address, data) between two writeback requesters, the ALU and the load/store unit (LSU), using valid/ready handshakes and round-robin arbitration. Optionally keeps a pending-load scoreboard so the hazard logic can stall reads of registers whose load data has not yet been written. Sits between the execute/memory stages and the regfile write port.

## Interface
- `STALL_CNT_W`, default 16: width of the saturating refused-request counter.
- `clk_i` input 1: clock, all state on rising edge.
- `rst_i` input 1: asynchronous, active-high reset.
- `alu_valid_i` input 1: ALU writeback request.
- `alu_rd_i` input 5: ALU destination register.
- `alu_data_i` input 32: ALU result.
- `alu_ready_o` output 1: ALU request accepted this cycle (combinational).
- `lsu_valid_i` input 1: LSU writeback request.
- `lsu_rd_i` input 5: LSU destination register.
- `lsu_data_i` input 32: load data.
- `lsu_ready_o` output 1: LSU request accepted this cycle (combinational).
- `rd_wren_o` output 1: regfile write enable (registered).
- `rd_addr_o` output 5: regfile write address (registered).
- `rd_data_o` output 32: regfile write data (registered).
- `issue_ld_i` input 1: a load is issued to the LSU this cycle.
- `issue_rd_i` input 5: destination of the issued load.
- `rs1_addr_i`, `rs2_addr_i` input 5 each: source registers being decoded.
- `rs1_busy_o`, `rs2_busy_o` output 1 each: source register has a pending load.
- `stall_cnt_o` output STALL_CNT_W: cycles in which a valid request was refused.

## Operation
- A handshake completes when valid and ready are both high in the same cycle; the requester holds rd and data stable while valid is high and ready is low.
- x0 requests (rd = 0): ready is high whenever valid is high, with no arbitration and no pointer update. Nothing is written; rd_wren_o stays 0 for them. Both requesters may be accepted in one cycle if at least one targets x0.
- Non-x0 arbitration: the two requesters compete for one write slot.
  - Only one valid: it is granted.
  - Both valid: grant goes to the requester not granted last. The one-bit pointer `last` has reset value ALU, so the LSU wins the first tie.
  - The pointer updates only on a granted non-x0 handshake.
- Registered write: on a granted non-x0 handshake, the next cycle has rd_wren_o=1, and rd_addr_o/rd_data_o take the granted rd/data. With no grant, rd_wren_o=0 and addr/data hold their previous values.
- Stall counter: increments by 1 in each cycle where at least one valid non-x0 request has ready low. It saturates at all-ones and never wraps.
- Scoreboard (when compiled in): 31 busy bits for x1..x31.
  - Set: `issue_ld_i` with `issue_rd_i` ≠ 0 sets busy[issue_rd_i].
  - Clear: a granted non-x0 LSU handshake clears busy[lsu_rd_i].
  - Set and clear to the same register in the same cycle: set wins.
  - Busy for x0 is always 0.
  - `rsN_busy_o` is a combinational read of the busy bits, reflecting the state before the current edge.

## Timing
- Ready: combinational from valid/rd and `last`; zero-cycle grant.
- Latency: accepted request to rd_wren_o is exactly 1 cycle. Sustained throughput is one regfile write per cycle.
- Under continuous contention, ALU and LSU grants alternate every cycle.
- Reset (asynchronous, any time, including with a write pending in the output register):
  - rd_wren_o=0, rd_addr_o=0, rd_data_o=0.
  - `last`=ALU, stall_cnt_o=0, all busy bits 0.
  - A pending write is discarded, not delayed.
- While rst_i is high, alu_ready_o and lsu_ready_o are 0.

## Configuration
- `RF_SCOREBOARD_EN` defined: scoreboard present as described.
- `RF_SCOREBOARD_EN` undefined: no busy storage. rs1_busy_o and rs2_busy_o are tied to 0; issue_ld_i and issue_rd_i are ignored. Arbitration, the write path and the stall counter are unchanged.

## Test plan
- Reset release:
  - Stimulus: hold rst_i high, then release.
  - Required: all outputs 0; with no valids for 5 cycles, rd_wren_o stays 0.
- Single ALU write:
  - Stimulus: alu_valid_i=1, alu_rd_i=5, alu_data_i=0xDEADBEEF for one cycle.
  - Required: alu_ready_o=1 the same cycle; next cycle rd_wren_o=1, rd_addr_o=5, rd_data_o=0xDEADBEEF.
- Contention:
  - Stimulus: both valid for 4 cycles (ALU rd=1, LSU rd=2), each requester holding its request until accepted.
  - Required: grant order LSU, ALU, LSU, ALU; stall_cnt_o=4.
- x0 handling:
  - Stimulus: ALU rd=0 and LSU rd=3 valid together.
  - Required: both ready high; next cycle a single write of x3; stall_cnt_o unchanged.
- Scoreboard (macro defined):
  - Stimulus: issue_ld_i with rd=7; rs1_addr_i=7 the next cycle.
  - Required: rs1_busy_o=1.
  - Stimulus: LSU writes x7 in the same cycle a new load to x7 issues.
  - Required: busy[7] remains 1.
  - Required with the macro undefined: rs1_busy_o=0 throughout.
- Reset mid-operation and saturation:
  - Stimulus: assert rst_i between an accepted handshake and the next clock edge.
  - Required: no write appears.
  - Stimulus: with STALL_CNT_W=4, refuse requests for 20 cycles.
  - Required: stall_cnt_o holds at 15.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Regfile write-port arbiter: round-robin ALU/LSU writeback with a registered write port.
// Optional pending-load scoreboard compiled in with `define RF_SCOREBOARD_EN.
module regfile_wb_arbiter #(
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   alu_valid_i,
  input  logic [4:0]             alu_rd_i,
  input  logic [31:0]            alu_data_i,
  output logic                   alu_ready_o,
  input  logic                   lsu_valid_i,
  input  logic [4:0]             lsu_rd_i,
  input  logic [31:0]            lsu_data_i,
  output logic                   lsu_ready_o,
  output logic                   rd_wren_o,
  output logic [4:0]             rd_addr_o,
  output logic [31:0]            rd_data_o,
  input  logic                   issue_ld_i,
  input  logic [4:0]             issue_rd_i,
  input  logic [4:0]             rs1_addr_i,
  input  logic [4:0]             rs2_addr_i,
  output logic                   rs1_busy_o,
  output logic                   rs2_busy_o,
  output logic [STALL_CNT_W-1:0] stall_cnt_o
);

  typedef enum logic {SRC_ALU = 1'b0, SRC_LSU = 1'b1} src_e;

  src_e last;
  logic alu_nz, lsu_nz;
  logic grant_alu, grant_lsu;
  logic stall_evt;

  always_comb begin
    alu_nz    = alu_valid_i && (alu_rd_i != 5'd0);
    lsu_nz    = lsu_valid_i && (lsu_rd_i != 5'd0);
    grant_lsu = lsu_nz && (!alu_nz || (last == SRC_ALU));
    grant_alu = alu_nz && (!lsu_nz || (last == SRC_LSU));
    // x0 requests bypass arbitration; everything is refused while in reset
    alu_ready_o = !rst_i && ((alu_valid_i && (alu_rd_i == 5'd0)) || grant_alu);
    lsu_ready_o = !rst_i && ((lsu_valid_i && (lsu_rd_i == 5'd0)) || grant_lsu);
    stall_evt   = (alu_nz && !grant_alu) || (lsu_nz && !grant_lsu);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last        <= SRC_ALU;
      rd_wren_o   <= 1'b0;
      rd_addr_o   <= '0;
      rd_data_o   <= '0;
      stall_cnt_o <= '0;
    end else begin
      rd_wren_o <= grant_alu || grant_lsu;
      if (grant_lsu) begin
        last      <= SRC_LSU;
        rd_addr_o <= lsu_rd_i;
        rd_data_o <= lsu_data_i;
      end else if (grant_alu) begin
        last      <= SRC_ALU;
        rd_addr_o <= alu_rd_i;
        rd_data_o <= alu_data_i;
      end
      if (stall_evt && (stall_cnt_o != '1))
        stall_cnt_o <= stall_cnt_o + STALL_CNT_W'(1);
    end
  end

`ifdef RF_SCOREBOARD_EN
  logic [31:0] busy;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy <= '0;
    end else begin
      // clear first so a same-cycle set to the same register wins
      if (grant_lsu)
        busy[lsu_rd_i] <= 1'b0;
      if (issue_ld_i && (issue_rd_i != 5'd0))
        busy[issue_rd_i] <= 1'b1;
    end
  end

  always_comb begin
    rs1_busy_o = (rs1_addr_i != 5'd0) && busy[rs1_addr_i];
    rs2_busy_o = (rs2_addr_i != 5'd0) && busy[rs2_addr_i];
  end
`else
  logic unused_sb;
  assign unused_sb  = ^{issue_ld_i, issue_rd_i, rs1_addr_i, rs2_addr_i};
  assign rs1_busy_o = 1'b0;
  assign rs2_busy_o = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter (default and 4-bit stall counter instances).
module tb_regfile_wb_arbiter;

`ifdef RF_SCOREBOARD_EN
  localparam logic SB = 1'b1;
`else
  localparam logic SB = 1'b0;
`endif

  logic        clk, rst;
  logic        alu_valid, lsu_valid, issue_ld;
  logic [4:0]  alu_rd, lsu_rd, issue_rd, rs1_addr, rs2_addr;
  logic [31:0] alu_data, lsu_data;

  logic        alu_ready, lsu_ready, rd_wren, rs1_busy, rs2_busy;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic [15:0] stall_cnt;

  logic        s_alu_ready, s_lsu_ready, s_rd_wren, s_rs1_busy, s_rs2_busy;
  logic [4:0]  s_rd_addr;
  logic [31:0] s_rd_data;
  logic [3:0]  s_stall_cnt;

  int n_checks = 0;
  int n_fails  = 0;

  regfile_wb_arbiter dut (
    .clk_i(clk), .rst_i(rst),
    .alu_valid_i(alu_valid), .alu_rd_i(alu_rd), .alu_data_i(alu_data), .alu_ready_o(alu_ready),
    .lsu_valid_i(lsu_valid), .lsu_rd_i(lsu_rd), .lsu_data_i(lsu_data), .lsu_ready_o(lsu_ready),
    .rd_wren_o(rd_wren), .rd_addr_o(rd_addr), .rd_data_o(rd_data),
    .issue_ld_i(issue_ld), .issue_rd_i(issue_rd),
    .rs1_addr_i(rs1_addr), .rs2_addr_i(rs2_addr),
    .rs1_busy_o(rs1_busy), .rs2_busy_o(rs2_busy),
    .stall_cnt_o(stall_cnt)
  );

  regfile_wb_arbiter #(.STALL_CNT_W(4)) dut_sat (
    .clk_i(clk), .rst_i(rst),
    .alu_valid_i(alu_valid), .alu_rd_i(alu_rd), .alu_data_i(alu_data), .alu_ready_o(s_alu_ready),
    .lsu_valid_i(lsu_valid), .lsu_rd_i(lsu_rd), .lsu_data_i(lsu_data), .lsu_ready_o(s_lsu_ready),
    .rd_wren_o(s_rd_wren), .rd_addr_o(s_rd_addr), .rd_data_o(s_rd_data),
    .issue_ld_i(issue_ld), .issue_rd_i(issue_rd),
    .rs1_addr_i(rs1_addr), .rs2_addr_i(rs2_addr),
    .rs1_busy_o(s_rs1_busy), .rs2_busy_o(s_rs2_busy),
    .stall_cnt_o(s_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
    issue_ld = 0; issue_rd = 0; rs1_addr = 0; rs2_addr = 0;

    // reset: requests refused while rst is high
    repeat (2) @(negedge clk);
    alu_valid = 1; alu_rd = 5'd1; lsu_valid = 1; lsu_rd = 5'd2;
    #1;
    chk("rst_alu_ready", alu_ready, 0);
    chk("rst_lsu_ready", lsu_ready, 0);
    chk("rst_wren", rd_wren, 0);
    @(negedge clk);
    chk("rst_stall", stall_cnt, 0);
    alu_valid = 0; lsu_valid = 0; alu_rd = 0; lsu_rd = 0;
    rst = 1'b0;
    #1;
    chk("rel_addr", rd_addr, 0);
    chk("rel_data", rd_data, 0);
    chk("rel_busy1", rs1_busy, 0);
    repeat (5) begin
      @(negedge clk);
      chk("idle_wren", rd_wren, 0);
    end

    // single ALU write
    alu_valid = 1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    #1;
    chk("single_alu_ready", alu_ready, 1);
    chk("single_lsu_ready", lsu_ready, 0);
    @(negedge clk);
    alu_valid = 0;
    chk("single_wren", rd_wren, 1);
    chk("single_addr", rd_addr, 5);
    chk("single_data", rd_data, 32'hDEADBEEF);
    @(negedge clk);
    chk("single_after_wren", rd_wren, 0);
    chk("single_hold_addr", rd_addr, 5);

    // contention: last=ALU so LSU first, then alternate
    alu_valid = 1; alu_rd = 5'd1; alu_data = 32'hA1;
    lsu_valid = 1; lsu_rd = 5'd2; lsu_data = 32'hB2;
    #1;
    chk("cont1_lsu_ready", lsu_ready, 1);
    chk("cont1_alu_ready", alu_ready, 0);
    @(negedge clk);
    chk("cont1_addr", rd_addr, 2);
    chk("cont1_data", rd_data, 32'hB2);
    #1;
    chk("cont2_alu_ready", alu_ready, 1);
    chk("cont2_lsu_ready", lsu_ready, 0);
    @(negedge clk);
    chk("cont2_addr", rd_addr, 1);
    chk("cont2_data", rd_data, 32'hA1);
    #1;
    chk("cont3_lsu_ready", lsu_ready, 1);
    @(negedge clk);
    chk("cont3_addr", rd_addr, 2);
    #1;
    chk("cont4_alu_ready", alu_ready, 1);
    @(negedge clk);
    alu_valid = 0; lsu_valid = 0;
    chk("cont4_addr", rd_addr, 1);
    chk("cont4_wren", rd_wren, 1);
    chk("cont_stall", stall_cnt, 4);

    // x0 from ALU alongside LSU x3
    alu_valid = 1; alu_rd = 5'd0; alu_data = 32'h55;
    lsu_valid = 1; lsu_rd = 5'd3; lsu_data = 32'hC3;
    #1;
    chk("x0_alu_ready", alu_ready, 1);
    chk("x0_lsu_ready", lsu_ready, 1);
    @(negedge clk);
    alu_valid = 0; lsu_valid = 0;
    chk("x0_wren", rd_wren, 1);
    chk("x0_addr", rd_addr, 3);
    chk("x0_data", rd_data, 32'hC3);
    chk("x0_stall", stall_cnt, 4);
    @(negedge clk);
    chk("x0_after_wren", rd_wren, 0);

    // scoreboard: set, set-wins-over-clear, clear
    issue_ld = 1; issue_rd = 5'd7; rs1_addr = 5'd7;
    #1;
    chk("sb_pre_busy", rs1_busy, 0);
    @(negedge clk);
    issue_ld = 0;
    #1;
    chk("sb_set_busy", rs1_busy, SB);
    @(negedge clk);
    lsu_valid = 1; lsu_rd = 5'd7; lsu_data = 32'h77;
    issue_ld = 1; issue_rd = 5'd7;
    #1;
    chk("sb_lsu_ready", lsu_ready, 1);
    @(negedge clk);
    lsu_valid = 0; issue_ld = 0;
    chk("sb_wr_addr", rd_addr, 7);
    chk("sb_setwins_busy", rs1_busy, SB);
    lsu_valid = 1; lsu_data = 32'h78; rs2_addr = 5'd7;
    #1;
    chk("sb_rs2_busy", rs2_busy, SB);
    @(negedge clk);
    lsu_valid = 0;
    chk("sb_clear_busy", rs1_busy, 0);
    chk("sb_clear_data", rd_data, 32'h78);

    // reset between an accepted handshake and its clock edge
    alu_valid = 1; alu_rd = 5'd9; alu_data = 32'h99;
    #1;
    chk("mid_alu_ready", alu_ready, 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_ready_in_rst", alu_ready, 0);
    chk("mid_wren_in_rst", rd_wren, 0);
    @(negedge clk);
    alu_valid = 0; rst = 1'b0;
    #1;
    chk("mid_wren", rd_wren, 0);
    chk("mid_addr", rd_addr, 0);
    chk("mid_data", rd_data, 0);
    @(negedge clk);
    chk("mid_wren2", rd_wren, 0);

    // stall saturation: 20 cycles with one refused request each
    alu_valid = 1; alu_rd = 5'd1; lsu_valid = 1; lsu_rd = 5'd2;
    repeat (10) @(negedge clk);
    chk("sat10_small", s_stall_cnt, 10);
    chk("sat10_wide", stall_cnt, 10);
    repeat (10) @(negedge clk);
    alu_valid = 0; lsu_valid = 0;
    chk("sat20_small", s_stall_cnt, 15);
    chk("sat20_wide", stall_cnt, 20);
    @(negedge clk);
    chk("sat_hold", s_stall_cnt, 15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
